// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with iterative shifts, shift-add multiply and restoring divide
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] hi,
    output logic [7:0]       flags
);
    localparam int SA = $clog2(WIDTH);
    localparam logic [3:0] OP_AND = 4'h0, OP_OR = 4'h1, OP_XOR = 4'h2, OP_NOT = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SUB = 4'h6, OP_SBB = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_SAR = 4'hA, OP_ROL = 4'hB;
    localparam logic [3:0] OP_ROR = 4'hC, OP_MUL = 4'hD, OP_DIVU = 4'hE, OP_CMP = 4'hF;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_p, r_q;
    logic [SA:0]      r_cnt;

    logic             w_ci, w_sh_cy, w_div0, w_last, w_ge, w_cy, w_ac, w_ov, w_wr;
    logic [WIDTH:0]   w_sum, w_dif, w_madd, w_t;
    logic [WIDTH-1:0] w_sh_q, w_mp, w_mq, w_dp, w_dq, w_res, w_hi;
    logic [SA-1:0]    w_n;
    logic [SA:0]      w_lim;

    // ADC/SBB pull in the carry left by the previous operation
    assign w_ci  = (r_op == OP_ADC || r_op == OP_SBB) ? flags[0] : 1'b0;
    assign w_sum = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, w_ci};
    assign w_dif = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, w_ci};

    // r_q is the working operand for shifts; one position per step
    assign w_sh_q  = r_op == OP_SHL ? {r_q[WIDTH-2:0], 1'b0} :
                     r_op == OP_SHR ? {1'b0, r_q[WIDTH-1:1]} :
                     r_op == OP_SAR ? {r_q[WIDTH-1], r_q[WIDTH-1:1]} :
                     r_op == OP_ROL ? {r_q[WIDTH-2:0], r_q[WIDTH-1]} :
                                      {r_q[0], r_q[WIDTH-1:1]};
    assign w_sh_cy = (r_op == OP_SHL || r_op == OP_ROL) ? r_q[WIDTH-1] : r_q[0];

    // multiply: r_p is the running high half, r_q holds the multiplier shifting out
    assign w_madd = {1'b0, r_p} + (r_q[0] ? {1'b0, r_a} : '0);
    assign w_mp   = w_madd[WIDTH:1];
    assign w_mq   = {w_madd[0], r_q[WIDTH-1:1]};

    // divide: r_p is the partial remainder, r_q shifts dividend out and quotient in
    assign w_t  = {r_p, r_q[WIDTH-1]};
    assign w_ge = w_t >= {1'b0, r_b};
    assign w_dp = w_ge ? WIDTH'(w_t - {1'b0, r_b}) : w_t[WIDTH-1:0];
    assign w_dq = {r_q[WIDTH-2:0], w_ge};

    assign w_n    = r_b[SA-1:0];
    assign w_div0 = r_op == OP_DIVU && r_b == '0;
    assign w_lim  = (r_op == OP_MUL || r_op == OP_DIVU) ? (SA+1)'(WIDTH) :
                    (r_op >= OP_SHL && r_op <= OP_ROR && w_n != '0) ? {1'b0, w_n} : (SA+1)'(1);
    assign w_last = w_div0 || r_cnt == w_lim - 1'b1;

    // final result and flag sources for the completing step; CMP computes but does not write c/hi
    always_comb begin
        w_res = r_q;
        w_hi  = '0;
        w_cy  = 1'b0;
        w_ac  = 1'b0;
        w_ov  = 1'b0;
        w_wr  = 1'b1;
        case (r_op)
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_NOT: w_res = ~r_a;
            OP_ADD, OP_ADC: begin
                w_res = w_sum[WIDTH-1:0];
                w_cy  = w_sum[WIDTH];
                w_ac  = r_a[4] ^ r_b[4] ^ w_sum[4];
                w_ov  = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum[WIDTH-1] ^ w_sum[WIDTH];
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                w_res = w_dif[WIDTH-1:0];
                w_cy  = w_dif[WIDTH];
                w_ac  = r_a[4] ^ r_b[4] ^ w_dif[4];
                w_ov  = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_dif[WIDTH-1] ^ w_dif[WIDTH];
                w_wr  = r_op != OP_CMP;
            end
            OP_MUL: begin
                w_res = w_mq;
                w_hi  = w_mp;
                w_cy  = |w_mp;
                w_ov  = |w_mp;
            end
            OP_DIVU: begin
                w_res = w_div0 ? '1 : w_dq;
                w_hi  = w_div0 ? r_a : w_dp;
                w_cy  = w_div0;
                w_ov  = w_div0;
            end
            default: begin
                w_res = w_n == '0 ? r_q : w_sh_q;
                w_cy  = w_n != '0 && w_sh_cy;
            end
        endcase
    end

    // controller: latch on accept, iterate in EXEC, write registered results on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            c       <= '0;
            hi      <= '0;
            flags   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= EXEC;
                    busy    <= 1'b1;
                    r_cnt   <= '0;
                    r_op    <= op;
                    r_a     <= a;
                    r_b     <= b;
                    r_p     <= '0;
                    r_q     <= op == OP_MUL ? b : a;
                end
                EXEC: if (w_last) begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    c       <= w_wr ? w_res : c;
                    hi      <= w_wr ? w_hi : hi;
                    flags   <= {2'b00, w_ov, ~^w_res, w_res[WIDTH-1], w_res == '0, w_ac, w_cy};
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    r_p   <= r_op == OP_MUL ? w_mp : w_dp;
                    r_q   <= r_op == OP_MUL ? w_mq : r_op == OP_DIVU ? w_dq : w_sh_q;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: vector table, multi-cycle corner sequences and randomized ops against an arithmetic model
module tb_alu_mc;
    logic       clk = 1'b0;
    logic       rst, start, busy, done;
    logic [3:0] op;
    logic [7:0] a, b, c, hi, flags;

    int checks = 0;
    int errors = 0;

    logic       m_cy;
    logic [7:0] m_c, m_hi;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, c, hi, fl;
        int lat;
    } vec_t;
    vec_t tv[12];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .c(c), .hi(hi), .flags(flags)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // expected results straight from the operation definitions, tracking c/hi/carry between ops
    task automatic model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         output logic [7:0] ec, output logic [7:0] eh, output logic [7:0] ef,
                         output int lat);
        int xi, yi, sx, sy, ci, n, r, sr, p;
        logic cy, ac, ov;
        logic [7:0] res, h, fs;
        xi = x; yi = y; sx = $signed(x); sy = $signed(y);
        ci = (o == 5 || o == 7) ? int'(m_cy) : 0;
        n = yi % 8;
        cy = 0; ac = 0; ov = 0; h = 0; lat = 1; res = 0; r = 0;
        case (o)
            0: res = x & y;
            1: res = x | y;
            2: res = x ^ y;
            3: res = ~x;
            4, 5: begin
                r = xi + yi + ci; res = r[7:0]; cy = r > 255;
                ac = (xi % 16) + (yi % 16) + ci > 15;
                sr = sx + sy + ci; ov = sr > 127 || sr < -128;
            end
            6, 7, 15: begin
                r = xi - yi - ci; res = r[7:0]; cy = r < 0;
                ac = (xi % 16) - (yi % 16) - ci < 0;
                sr = sx - sy - ci; ov = sr > 127 || sr < -128;
            end
            8:  begin res = x << n; cy = n != 0 && x[8-n]; end
            9:  begin res = x >> n; cy = n != 0 && x[n-1]; end
            10: begin res = $signed(x) >>> n; cy = n != 0 && x[n-1]; end
            11: begin res = (x << n) | (x >> (8 - n)); cy = n != 0 && x[(8-n)%8]; end
            12: begin res = (x >> n) | (x << (8 - n)); cy = n != 0 && x[n-1]; end
            13: begin p = xi * yi; res = p[7:0]; h = p[15:8]; cy = h != 0; ov = cy; lat = 8; end
            default: begin
                if (yi == 0) begin res = 8'hFF; h = x; cy = 1; ov = 1; end
                else begin res = 8'(xi / yi); h = 8'(xi % yi); lat = 8; end
            end
        endcase
        if (o >= 8 && o <= 12 && n != 0) lat = n;
        fs = res;
        ef = {2'b00, ov, ~^fs, fs[7], fs == 0, ac, cy};
        if (o == 15) begin res = m_c; h = m_hi; end
        ec = res; eh = h;
        m_c = res; m_hi = h; m_cy = cy;
    endtask

    // issue one op, scramble inputs after acceptance, count edges until done
    task automatic run(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
    endtask

    initial begin
        logic [7:0] ec, eh, ef;
        int el, lat, seen;
        tv[0]  = '{4'h4, 8'h7F, 8'h01, 8'h80, 8'h00, 8'h2A, 1};
        tv[1]  = '{4'h6, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h1B, 1};
        tv[2]  = '{4'h7, 8'h05, 8'h02, 8'h02, 8'h00, 8'h00, 1};
        tv[3]  = '{4'hD, 8'hFF, 8'hFF, 8'h01, 8'hFE, 8'h21, 8};
        tv[4]  = '{4'hE, 8'h64, 8'h07, 8'h0E, 8'h02, 8'h00, 8};
        tv[5]  = '{4'hE, 8'h5A, 8'h00, 8'hFF, 8'h5A, 8'h39, 1};
        tv[6]  = '{4'hC, 8'h81, 8'h03, 8'h30, 8'h00, 8'h10, 3};
        tv[7]  = '{4'hA, 8'h80, 8'h00, 8'h80, 8'h00, 8'h08, 1};
        tv[8]  = '{4'hF, 8'h05, 8'h05, 8'h80, 8'h00, 8'h14, 1};
        tv[9]  = '{4'h3, 8'h0F, 8'h33, 8'hF0, 8'h00, 8'h18, 1};
        tv[10] = '{4'h8, 8'h81, 8'h01, 8'h02, 8'h00, 8'h01, 1};
        tv[11] = '{4'hB, 8'h81, 8'h07, 8'hC0, 8'h00, 8'h18, 7};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        m_cy = 0; m_c = 0; m_hi = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_c", c, 0);
        chk("reset_hi", hi, 0);
        chk("reset_flags", flags, 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            model(tv[i].op, tv[i].a, tv[i].b, ec, eh, ef, el);
            run(tv[i].op, tv[i].a, tv[i].b, lat);
            chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
            chk($sformatf("vec%0d_c", i), c, tv[i].c);
            chk($sformatf("vec%0d_hi", i), hi, tv[i].hi);
            chk($sformatf("vec%0d_flags", i), flags, tv[i].fl);
            chk($sformatf("vec%0d_busy", i), busy, 0);
        end

        // MUL with start held high throughout: extra requests must be ignored
        model(4'hD, 8'hFF, 8'hFF, ec, eh, ef, el);
        @(negedge clk);
        op = 4'hD; a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        op = 4'h4; a = 8'h01; b = 8'h01;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            chk("busy_hold", busy, 1);
            chk("c_hold", c, 8'hC0);
        end
        start = 1'b0;
        chk("ign_lat", lat, 8);
        chk("ign_c", c, 8'h01);
        chk("ign_hi", hi, 8'hFE);
        chk("ign_flags", flags, 8'h21);
        @(posedge clk); #1;
        chk("ign_no_extra_done", done, 0);
        chk("ign_idle", busy, 0);

        // reset in the middle of a MUL, with start asserted in the same cycle
        @(negedge clk);
        op = 4'hD; a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 4'h4;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_c", c, 0);
        chk("rst_hi", hi, 0);
        chk("rst_flags", flags, 0);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("rst_no_done", seen, 0);
        m_cy = 0; m_c = 0; m_hi = 0;
        model(4'h5, 8'h03, 8'h04, ec, eh, ef, el);
        run(4'h5, 8'h03, 8'h04, lat);
        chk("post_rst_lat", lat, el);
        chk("post_rst_c", c, ec);
        chk("post_rst_flags", flags, ef);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] o;
            logic [7:0] x, y;
            o = 4'($urandom);
            x = 8'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            model(o, x, y, ec, eh, ef, el);
            run(o, x, y, lat);
            chk($sformatf("rnd%0d_op%0h_lat", i, o), lat, el);
            chk($sformatf("rnd%0d_op%0h_c", i, o), c, ec);
            chk($sformatf("rnd%0d_op%0h_hi", i, o), hi, eh);
            chk($sformatf("rnd%0d_op%0h_flags", i, o), flags, ef);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
